id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core. It captures the two register-file read operands,
//  the extended immediate, register addresses, control bundle and PC+4 for the execute stage.
//  It also owns load-use hazard detection: it stalls PC/IF-ID and inserts a bubble into EX.
//  Branch flush and debug halt are driven from outside.
// PARAMETERS
//  NB_DATA  32  operand/PC width
//  NB_ADDR  5   register address width
//  NB_IMM   16  raw immediate width
//  NB_CTRL  16  control bundle width; bit positions come from the shared package
// PORTS
//  clk         in   1        clock, rising edge
//  i_rst_n     in   1        reset, asynchronous, active-low
//  i_halt      in   1        debug freeze; holds all state
//  i_flush     in   1        branch/jump resolved taken; kill the ID instruction
//  i_valid     in   1        ID holds a real instruction
//  i_rs_addr   in   NB_ADDR  rs field
//  i_rt_addr   in   NB_ADDR  rt field
//  i_rd_addr   in   NB_ADDR  rd field
//  i_uses_rt   in   1        ID instruction reads rt as a source
//  i_rs_data   in   NB_DATA  register-file read port 1
//  i_rt_data   in   NB_DATA  register-file read port 2
//  i_imm       in   NB_IMM   raw immediate
//  i_imm_sext  in   1        1 = sign-extend, 0 = zero-extend
//  i_shamt     in   5        shift amount
//  i_ctrl      in   NB_CTRL  decoded control bundle
//  i_pc_plus4  in   NB_DATA  PC+4 of the ID instruction
//  o_valid     out  1        EX holds a real instruction
//  o_rs_data   out  NB_DATA  registered rs operand
//  o_rt_data   out  NB_DATA  registered rt operand
//  o_imm_ext   out  NB_DATA  registered extended immediate
//  o_shamt     out  5        registered shift amount
//  o_rs_addr   out  NB_ADDR  registered rs address, for forwarding
//  o_rt_addr   out  NB_ADDR  registered rt address
//  o_rd_addr   out  NB_ADDR  registered rd address
//  o_ctrl      out  NB_CTRL  registered control bundle
//  o_pc_plus4  out  NB_DATA  registered PC+4
//  o_stall     out  1        combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (asynchronous, any time, including mid-stall): every registered output is 0, so o_stall = 0.
//  - Register file writes on negedge and reads combinationally. i_rs_data/i_rt_data therefore already
//    contain the WB write of the same cycle; this block adds no WB bypass.
//  - hazard = o_valid & o_ctrl[CTRL_MEM_READ] & i_valid & (o_rt_addr != 0)
//    & ((o_rt_addr == i_rs_addr) | (i_uses_rt & (o_rt_addr == i_rt_addr))).
//  - o_stall = hazard & ~i_flush & ~i_halt.
//  - Rising-edge priority, highest first:
//    1. i_halt: all registers hold.
//    2. i_flush: load bubble.
//    3. hazard: load bubble.
//    4. Otherwise load all fields, with o_valid <= i_valid.
//  - Bubble: o_valid, o_ctrl and all data/address fields become 0. ctrl = 0 means no reg/mem write.
//  - Immediate: i_imm_sext = 1 replicates i_imm[NB_IMM-1]; i_imm_sext = 0 zero-fills.
//  - Latency: 1 cycle ID->EX. A load-use stall costs exactly 1 bubble; the held instruction is
//    re-evaluated the next cycle and then passes.
//  - Halt during a hazard: o_stall = 0, but the PC is frozen by the halt anyway. On release, the hazard
//    re-evaluates.
// STRUCTURE
//  - mips_pkg: CTRL_* bit indices (CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_MEM_TO_REG,
//    CTRL_ALU_SRC, CTRL_REG_DST, CTRL_ALU_OP range), NB_CTRL, REG_ZERO = 5'd0.
//  - One sub-module: hazard_detect_unit, a purely combinational block producing hazard.
//    id_ex_stage holds the registers and the priority logic.
// TESTING
//  1. EX: lw $9; ID: add rs=$9 -> o_stall=1 for 1 cycle; next o_valid=0 and o_ctrl=0;
//     then o_valid=1 with the add fields.
//  2. EX: lw $0; ID: rs=$0 -> o_stall=0, no bubble.
//     EX: lw $9; ID: rt=$9 with i_uses_rt=0 -> no stall.
//  3. Hazard and i_flush together -> o_stall=0, bubble loaded, next o_valid=0.
//  4. i_imm=16'h8000: sext=1 -> o_imm_ext=32'hFFFF8000; sext=0 -> 32'h00008000.
//  5. i_halt=1 for 3 cycles with changing inputs -> outputs constant. Release -> next input loaded.
//  6. Assert i_rst_n=0 asynchronously mid-stall -> all outputs 0 immediately, o_stall=0.
//     Then release and run a normal 5-instruction stream.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Provides the control-bundle bit layout, its width and the hard-wired
// zero register address. Stages index the control bundle only through
// these names, so the layout can change in one place.
package mips_pkg;

    localparam int NB_CTRL = 16;

    // Control bundle bit positions
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_OP_MSB = 9;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection, purely combinational.
// A hazard exists when the instruction in EX is a valid load whose
// destination (rt, non-zero) is read as a source by the valid ID instruction.
// Ports:
//   ex_valid, ex_mem_read, ex_rt_addr : load candidate currently in EX
//   id_valid, id_rs_addr, id_rt_addr  : instruction currently in ID
//   id_uses_rt                        : ID instruction reads rt as a source
//   hazard                            : 1 = ID must wait one cycle
import mips_pkg::*;

module hazard_detect_unit #(
    parameter int NB_ADDR = 5
) (
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [NB_ADDR-1:0] ex_rt_addr,
    input  logic               id_valid,
    input  logic [NB_ADDR-1:0] id_rs_addr,
    input  logic [NB_ADDR-1:0] id_rt_addr,
    input  logic               id_uses_rt,
    output logic               hazard
);

    logic rs_match;
    logic rt_match;
    logic dest_nonzero;

    // $0 is never written, so a load targeting it cannot create a dependency.
    assign dest_nonzero = (ex_rt_addr != NB_ADDR'(REG_ZERO));
    assign rs_match     = (ex_rt_addr == id_rs_addr);
    assign rt_match     = id_uses_rt & (ex_rt_addr == id_rt_addr);

    assign hazard = ex_valid & ex_mem_read & id_valid & dest_nonzero
                  & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation.
// Captures operands, extended immediate, register addresses, control bundle
// and PC+4 for EX. On a load-use hazard it asserts o_stall (holding PC and
// IF/ID) and loads a bubble; branch flush also loads a bubble; debug halt
// freezes every register.
// Ports:
//   clk, i_rst_n                         : clock, async active-low reset
//   i_halt, i_flush                      : freeze / kill ID instruction
//   i_valid, i_rs/rt/rd_addr, i_uses_rt  : ID instruction identity
//   i_rs_data, i_rt_data                 : register-file read data
//   i_imm, i_imm_sext, i_shamt           : immediate and shift amount
//   i_ctrl, i_pc_plus4                   : control bundle and PC+4
//   o_*                                  : registered EX-side copies
//   o_stall                              : combinational PC / IF-ID hold
import mips_pkg::*;

module id_ex_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_IMM  = 16,
    parameter int NB_CTRL = mips_pkg::NB_CTRL
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_ADDR-1:0] i_rs_addr,
    input  logic [NB_ADDR-1:0] i_rt_addr,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    input  logic               i_uses_rt,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_IMM-1:0]  i_imm,
    input  logic               i_imm_sext,
    input  logic [4:0]         i_shamt,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_pc_plus4,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm_ext,
    output logic [4:0]         o_shamt,
    output logic [NB_ADDR-1:0] o_rs_addr,
    output logic [NB_ADDR-1:0] o_rt_addr,
    output logic [NB_ADDR-1:0] o_rd_addr,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic               o_stall
);

    logic               hazard;
    logic               bubble;
    logic [NB_DATA-1:0] imm_ext;

    hazard_detect_unit #(
        .NB_ADDR (NB_ADDR)
    ) u_hazard (
        .ex_valid    (o_valid),
        .ex_mem_read (o_ctrl[CTRL_MEM_READ]),
        .ex_rt_addr  (o_rt_addr),
        .id_valid    (i_valid),
        .id_rs_addr  (i_rs_addr),
        .id_rt_addr  (i_rt_addr),
        .id_uses_rt  (i_uses_rt),
        .hazard      (hazard)
    );

    // A flush kills the ID instruction anyway, and a halt freezes the PC on
    // its own, so neither needs the stall.
    assign o_stall = hazard & ~i_flush & ~i_halt;
    assign bubble  = i_flush | hazard;

    assign imm_ext = {{(NB_DATA-NB_IMM){i_imm_sext & i_imm[NB_IMM-1]}}, i_imm};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_rs_data  <= '0;
            o_rt_data  <= '0;
            o_imm_ext  <= '0;
            o_shamt    <= '0;
            o_rs_addr  <= '0;
            o_rt_addr  <= '0;
            o_rd_addr  <= '0;
            o_ctrl     <= '0;
            o_pc_plus4 <= '0;
        end else if (!i_halt) begin
            if (bubble) begin
                o_valid    <= 1'b0;
                o_rs_data  <= '0;
                o_rt_data  <= '0;
                o_imm_ext  <= '0;
                o_shamt    <= '0;
                o_rs_addr  <= '0;
                o_rt_addr  <= '0;
                o_rd_addr  <= '0;
                o_ctrl     <= '0;
                o_pc_plus4 <= '0;
            end else begin
                o_valid    <= i_valid;
                o_rs_data  <= i_rs_data;
                o_rt_data  <= i_rt_data;
                o_imm_ext  <= imm_ext;
                o_shamt    <= i_shamt;
                o_rs_addr  <= i_rs_addr;
                o_rt_addr  <= i_rt_addr;
                o_rd_addr  <= i_rd_addr;
                o_ctrl     <= i_ctrl;
                o_pc_plus4 <= i_pc_plus4;
            end
        end
    end

endmodule
